// File: rtl/hazard_stall_control_pkg.sv
// Shared types and opcode constants for the stall/flush controller.
package hazard_stall_control_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazard_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  // True when the instruction format actually reads rs1.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == OPCODE_OP)    || (opcode == OPCODE_OPIMM)  ||
           (opcode == OPCODE_LOAD)  || (opcode == OPCODE_STORE)  ||
           (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JALR);
  endfunction

  // True when the instruction format actually reads rs2.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPCODE_OP) || (opcode == OPCODE_STORE) ||
           (opcode == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_stall_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_control.sv
// Stall/flush controller: resolves load-use, taken-branch and data-memory
// wait hazards that forwarding cannot cover.
//
// state      | meaning
// -----------|-------------------------------------------------------------
// RUN        | no multi-cycle hazard in progress
// LOAD_STALL | extra load-use bubbles still owed (remaining != 0)
// MEM_WAIT   | pipeline frozen on an outstanding data-memory request
module hazard_stall_control
  import hazard_stall_control_pkg::*;
#(
  parameter int LOAD_USE_PENALTY = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       if_id_opcode_ip,
  input  logic [4:0]       if_id_rs1_ip,
  input  logic [4:0]       if_id_rs2_ip,
  input  logic [6:0]       id_ex_opcode_ip,
  input  logic [4:0]       id_ex_dest_ip,
  input  logic             ex_branch_taken_ip,
  input  logic             dmem_req_ip,
  input  logic             dmem_ready_ip,
  output logic             pc_stall_op,
  output logic             if_id_stall_op,
  output logic             id_ex_bubble_op,
  output logic             if_id_flush_op,
  output logic             all_stall_op,
  output logic [1:0]       state_op,
  output logic [CNT_W-1:0] load_stall_count_op,
  output logic [CNT_W-1:0] flush_count_op,
  output logic             mem_timeout_op
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  // Bubbles still owed after the first one, which is issued in RUN.
  localparam logic [2:0] EXTRA_BUBBLES = 3'(LOAD_USE_PENALTY - 1);

  hazard_state_e     state_q, state_d;
  logic [2:0]        remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic              mem_stall;
  logic              load_use;
  logic              load_inc;
  logic              flush_inc;

  assign mem_stall = dmem_req_ip & ~dmem_ready_ip;

  // x0 never carries a real dependency, and only registers the format reads count.
  assign load_use = (id_ex_opcode_ip == OPCODE_LOAD) && (id_ex_dest_ip != 5'd0) &&
                    ((uses_rs1(if_id_opcode_ip) && (id_ex_dest_ip == if_id_rs1_ip)) ||
                     (uses_rs2(if_id_opcode_ip) && (id_ex_dest_ip == if_id_rs2_ip)));

  // Prioritised hazard resolution: memory wait, taken branch, owed bubbles, new load-use.
  always_comb begin
    pc_stall_op     = 1'b0;
    if_id_stall_op  = 1'b0;
    id_ex_bubble_op = 1'b0;
    if_id_flush_op  = 1'b0;
    all_stall_op    = 1'b0;
    load_inc        = 1'b0;
    flush_inc       = 1'b0;
    state_d         = state_q;
    remaining_d     = remaining_q;
    if (!reset) begin
      if (mem_stall) begin
        all_stall_op   = 1'b1;
        pc_stall_op    = 1'b1;
        if_id_stall_op = 1'b1;
        state_d        = MEM_WAIT;
      end else if (ex_branch_taken_ip) begin
        // The dependent instruction is flushed, so any owed bubbles are dropped.
        if_id_flush_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
        flush_inc       = 1'b1;
        remaining_d     = 3'd0;
        state_d         = RUN;
      end else if (remaining_q != 3'd0) begin
        // Also covers the first cycle out of MEM_WAIT when bubbles are still owed.
        pc_stall_op     = 1'b1;
        if_id_stall_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
        load_inc        = 1'b1;
        remaining_d     = remaining_q - 3'd1;
        state_d         = (remaining_q > 3'd1) ? LOAD_STALL : RUN;
      end else if (load_use) begin
        pc_stall_op     = 1'b1;
        if_id_stall_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
        load_inc        = 1'b1;
        remaining_d     = EXTRA_BUBBLES;
        state_d         = (EXTRA_BUBBLES != 3'd0) ? LOAD_STALL : RUN;
      end else begin
        state_d = RUN;
      end
    end
  end

  // State and owed-bubble register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      remaining_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Consecutive memory-wait cycles; the timeout flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (wait_cnt_q >= WAIT_LAST) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .inc   (load_inc),
    .clr   (reset),
    .count (load_stall_count_op)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (flush_inc),
    .clr   (reset),
    .count (flush_count_op)
  );

  assign state_op       = state_q;
  assign mem_timeout_op = timeout_q;

endmodule

// File: tb/tb_hazard_stall_control.sv
// Self-checking bench: two controller instances (penalty 1 with 4-bit
// counters, penalty 3 with 16-bit counters) share one stimulus stream and
// are checked every cycle against a behavioural model.
module tb_hazard_stall_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] if_id_opcode, id_ex_opcode;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_dest;
  logic br_taken, dmem_req, dmem_ready;

  logic a_pc, a_ifid, a_bub, a_fl, a_all, a_tmo;
  logic [1:0] a_state;
  logic [3:0] a_lsc, a_fc;
  logic b_pc, b_ifid, b_bub, b_fl, b_all, b_tmo;
  logic [1:0] b_state;
  logic [15:0] b_lsc, b_fc;

  int vectors = 0;
  int miscompares = 0;

  int pen [2] = '{1, 3};
  int cap [2] = '{15, 65535};
  int m_rem [2];
  int m_mw [2];
  int m_wcnt [2];
  int m_tmo [2];
  int m_lsc [2];
  int m_fc [2];

  always #5 clk = ~clk;

  hazard_stall_control #(.LOAD_USE_PENALTY(1), .MEM_TIMEOUT(TMO), .CNT_W(4)) u_p1 (
    .clk(clk), .reset(reset),
    .if_id_opcode_ip(if_id_opcode), .if_id_rs1_ip(if_id_rs1), .if_id_rs2_ip(if_id_rs2),
    .id_ex_opcode_ip(id_ex_opcode), .id_ex_dest_ip(id_ex_dest),
    .ex_branch_taken_ip(br_taken), .dmem_req_ip(dmem_req), .dmem_ready_ip(dmem_ready),
    .pc_stall_op(a_pc), .if_id_stall_op(a_ifid), .id_ex_bubble_op(a_bub),
    .if_id_flush_op(a_fl), .all_stall_op(a_all), .state_op(a_state),
    .load_stall_count_op(a_lsc), .flush_count_op(a_fc), .mem_timeout_op(a_tmo));

  hazard_stall_control #(.LOAD_USE_PENALTY(3), .MEM_TIMEOUT(TMO), .CNT_W(16)) u_p3 (
    .clk(clk), .reset(reset),
    .if_id_opcode_ip(if_id_opcode), .if_id_rs1_ip(if_id_rs1), .if_id_rs2_ip(if_id_rs2),
    .id_ex_opcode_ip(id_ex_opcode), .id_ex_dest_ip(id_ex_dest),
    .ex_branch_taken_ip(br_taken), .dmem_req_ip(dmem_req), .dmem_ready_ip(dmem_ready),
    .pc_stall_op(b_pc), .if_id_stall_op(b_ifid), .id_ex_bubble_op(b_bub),
    .if_id_flush_op(b_fl), .all_stall_op(b_all), .state_op(b_state),
    .load_stall_count_op(b_lsc), .flush_count_op(b_fc), .mem_timeout_op(b_tmo));

  function automatic bit hazard_now();
    bit r1, r2;
    r1 = (if_id_opcode == OP_R) || (if_id_opcode == OP_I) || (if_id_opcode == OP_LD) ||
         (if_id_opcode == OP_ST) || (if_id_opcode == OP_BR) || (if_id_opcode == OP_JR);
    r2 = (if_id_opcode == OP_R) || (if_id_opcode == OP_ST) || (if_id_opcode == OP_BR);
    return (id_ex_opcode == OP_LD) && (id_ex_dest != 0) &&
           ((r1 && (id_ex_dest == if_id_rs1)) || (r2 && (id_ex_dest == if_id_rs2)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit lu, ms;
    logic e_pc, e_ifid, e_bub, e_fl, e_all;
    int e_state;
    @(negedge clk);
    lu = hazard_now();
    ms = dmem_req && !dmem_ready;
    for (int k = 0; k < 2; k++) begin
      {e_pc, e_ifid, e_bub, e_fl, e_all} = 5'b0;
      if (!reset) begin
        if (ms) {e_pc, e_ifid, e_all} = 3'b111;
        else if (br_taken) {e_fl, e_bub} = 2'b11;
        else if (m_rem[k] > 0 || lu) {e_pc, e_ifid, e_bub} = 3'b111;
      end
      e_state = (m_mw[k] != 0) ? 2 : ((m_rem[k] != 0) ? 1 : 0);
      chk($sformatf("p%0d.pc_stall", k), 32'(k == 0 ? a_pc : b_pc), 32'(e_pc));
      chk($sformatf("p%0d.if_id_stall", k), 32'(k == 0 ? a_ifid : b_ifid), 32'(e_ifid));
      chk($sformatf("p%0d.id_ex_bubble", k), 32'(k == 0 ? a_bub : b_bub), 32'(e_bub));
      chk($sformatf("p%0d.if_id_flush", k), 32'(k == 0 ? a_fl : b_fl), 32'(e_fl));
      chk($sformatf("p%0d.all_stall", k), 32'(k == 0 ? a_all : b_all), 32'(e_all));
      chk($sformatf("p%0d.state", k), 32'(k == 0 ? a_state : b_state), 32'(e_state));
      chk($sformatf("p%0d.load_cnt", k), (k == 0) ? 32'(a_lsc) : 32'(b_lsc), 32'(m_lsc[k]));
      chk($sformatf("p%0d.flush_cnt", k), (k == 0) ? 32'(a_fc) : 32'(b_fc), 32'(m_fc[k]));
      chk($sformatf("p%0d.mem_timeout", k), 32'(k == 0 ? a_tmo : b_tmo), 32'(m_tmo[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_rem[k] = 0; m_mw[k] = 0; m_wcnt[k] = 0; m_tmo[k] = 0; m_lsc[k] = 0; m_fc[k] = 0;
      end else if (ms) begin
        m_mw[k] = 1;
        if (m_wcnt[k] < TMO) m_wcnt[k]++;
        if (m_wcnt[k] >= TMO) m_tmo[k] = 1;
      end else begin
        m_mw[k] = 0;
        m_wcnt[k] = 0;
        if (br_taken) begin
          m_rem[k] = 0;
          if (m_fc[k] < cap[k]) m_fc[k]++;
        end else if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_lsc[k] < cap[k]) m_lsc[k]++;
        end else if (lu) begin
          m_rem[k] = pen[k] - 1;
          if (m_lsc[k] < cap[k]) m_lsc[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic set_pipe(input logic [6:0] ido, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] exo, input logic [4:0] rd);
    if_id_opcode = ido; if_id_rs1 = rs1; if_id_rs2 = rs2;
    id_ex_opcode = exo; id_ex_dest = rd;
  endtask

  logic [6:0] ops [8] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JR, OP_J, OP_LUI};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_mw[k] = 0; m_wcnt[k] = 0; m_tmo[k] = 0; m_lsc[k] = 0; m_fc[k] = 0;
    end
    reset = 1'b1; br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    set_pipe(OP_I, 5'd0, 5'd0, OP_I, 5'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Load-use on rs1: LOAD x5 in ID/EX, ADD x6,x5,x7 in IF/ID.
    set_pipe(OP_R, 5'd5, 5'd7, OP_LD, 5'd5);
    step();
    chk("tp_load_cnt_p1", 32'(a_lsc), 32'd1);
    set_pipe(OP_R, 5'd5, 5'd7, OP_I, 5'd0);
    step(); step(); step();

    // No hazard: LOAD x0 vs rs1 x0, and OPIMM whose unused rs2 matches.
    set_pipe(OP_R, 5'd0, 5'd0, OP_LD, 5'd0);
    step();
    set_pipe(OP_I, 5'd6, 5'd5, OP_LD, 5'd5);
    step();

    // Taken branch together with a load-use.
    set_pipe(OP_R, 5'd5, 5'd7, OP_LD, 5'd5);
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    chk("tp_flush_cnt_p3", 32'(b_fc), 32'd1);
    chk("tp_load_cnt_after_br", 32'(a_lsc), 32'd1);
    set_pipe(OP_I, 5'd0, 5'd0, OP_I, 5'd0);
    step();

    // Three-cycle memory wait, then ready.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step(); step();
    dmem_ready = 1'b1;
    step();
    dmem_req = 1'b0;
    step();

    // Penalty 3 with a two-cycle freeze after the second bubble.
    set_pipe(OP_R, 5'd5, 5'd7, OP_LD, 5'd5);
    step();
    set_pipe(OP_R, 5'd5, 5'd7, OP_I, 5'd0);
    step();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step();
    dmem_ready = 1'b1;
    step();
    dmem_req = 1'b0;
    step();

    // Timeout after four wait cycles, sticky past ready, cleared by reset.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step(); step(); step(); step();
    dmem_ready = 1'b1;
    step();
    dmem_req = 1'b0;
    chk("tp_timeout_sticky", 32'(a_tmo), 32'd1);
    set_pipe(OP_R, 5'd5, 5'd7, OP_LD, 5'd5);
    step();
    set_pipe(OP_I, 5'd0, 5'd0, OP_I, 5'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Randomised traffic with dense register collisions.
    for (int n = 0; n < 700; n++) begin
      if_id_opcode = ops[$urandom_range(0, 7)];
      if_id_rs1 = 5'($urandom_range(0, 3));
      if_id_rs2 = 5'($urandom_range(0, 3));
      id_ex_opcode = ($urandom_range(0, 1) == 0) ? OP_LD : ops[$urandom_range(0, 7)];
      id_ex_dest = 5'($urandom_range(0, 3));
      br_taken = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 1) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
